// File: rtl/dpi_stream_sequencer_pkg.sv
// Shared widths, default timing and FSM encoding for the DPI stream sequencer.
// Optional statistics counters are enabled with the DPI_SEQ_STATS_EN macro (see top).
package dpi_stream_sequencer_pkg;
    localparam int STREAM_ID_W   = 6;
    localparam int NUM_STREAMS   = 64;
    localparam int BYTE_W        = 8;
    localparam int DEF_NUM_REGEX = 8;
    localparam int DEF_LOAD_GAP  = 2;
    localparam int DEF_DRAIN     = 4;
    localparam int CNT_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_STREAM,
        ST_DRAIN,
        ST_EOP,
        ST_RESULT
    } seq_state_t;

    // Down-counter preset for a phase lasting 'cycles' clock cycles (terminates at zero).
    function automatic logic [CNT_W-1:0] cnt_preset(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction
endpackage

// File: rtl/dpi_stream_sequencer_if.sv
// Packet ingress stream from the packet FIFO into the sequencer.
// master = FIFO side (drives bytes), slave = sequencer side (drives ready).
interface dpi_stream_sequencer_if;
    logic                                            pkt_valid;
    logic                                            pkt_ready;
    logic [dpi_stream_sequencer_pkg::BYTE_W-1:0]      pkt_data;
    logic                                            pkt_sop;
    logic                                            pkt_eop;
    logic [dpi_stream_sequencer_pkg::STREAM_ID_W-1:0] pkt_stream_id;

    modport master (
        output pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_stream_id,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_stream_id,
        output pkt_ready
    );
endinterface

// File: rtl/dpi_stream_sequencer_table.sv
// Per-stream regex enable-mask table plus "stream already seen" bitmap.
// A clear and a set of the seen bitmap in the same cycle leave only the set bit.
module dpi_stream_sequencer_table
    import dpi_stream_sequencer_pkg::*;
#(
    parameter int NUM_REGEX = DEF_NUM_REGEX
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_we,
    input  logic [STREAM_ID_W-1:0] i_wr_id,
    input  logic [NUM_REGEX-1:0]   i_wr_mask,
    input  logic [STREAM_ID_W-1:0] i_rd_id,
    output logic [NUM_REGEX-1:0]   o_rd_mask,
    input  logic [STREAM_ID_W-1:0] i_seen_id,
    output logic                   o_seen,
    input  logic                   i_set_seen,
    input  logic [STREAM_ID_W-1:0] i_set_id,
    input  logic                   i_clear_seen
);
    logic [NUM_REGEX-1:0]   r_mask [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] r_seen;

    // Table writes and seen-bitmap updates; the later set overrides the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seen <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                r_mask[i] <= '0;
            end
        end else begin
            if (i_we) begin
                r_mask[i_wr_id] <= i_wr_mask;
            end
            if (i_clear_seen) begin
                r_seen <= '0;
            end
            if (i_set_seen) begin
                r_seen[i_set_id] <= 1'b1;
            end
        end
    end

    assign o_rd_mask = r_mask[i_rd_id];
    assign o_seen    = r_seen[i_seen_id];
endmodule

// File: rtl/dpi_stream_sequencer.sv
// Sequences one packet at a time into the regex wrapper bank:
// load DFA state, stream bytes, drain the DFA pipeline, pulse eop, report fired.
// Optional macro DPI_SEQ_STATS_EN adds stat_pkts/stat_bytes/stat_drops counters.
// LOAD_GAP must be >= 2 and DRAIN >= 1.
module dpi_stream_sequencer
    import dpi_stream_sequencer_pkg::*;
#(
    parameter int NUM_REGEX = DEF_NUM_REGEX,
    parameter int LOAD_GAP  = DEF_LOAD_GAP,
    parameter int DRAIN     = DEF_DRAIN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dpi_stream_sequencer_if.slave  pkt,
    input  logic                   cfg_we,
    input  logic [STREAM_ID_W-1:0] cfg_stream_id,
    input  logic [NUM_REGEX-1:0]   cfg_enable_mask,
    input  logic                   cfg_clear_seen,
    output logic [STREAM_ID_W-1:0] stream_id,
    output logic                   load_state,
    output logic                   new_stream_id,
    output logic [BYTE_W-1:0]      char_in,
    output logic                   char_in_vld,
    output logic                   eop,
    output logic [NUM_REGEX-1:0]   enable,
    input  logic [NUM_REGEX-1:0]   fired,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [STREAM_ID_W-1:0] result_stream_id,
    output logic [NUM_REGEX-1:0]   result_fired,
    output logic                   busy
`ifdef DPI_SEQ_STATS_EN
    ,
    output logic [31:0]            stat_pkts,
    output logic [31:0]            stat_bytes,
    output logic [15:0]            stat_drops
`endif
);
    seq_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [BYTE_W-1:0]      r_held;
    logic                   r_held_eop;
    logic [STREAM_ID_W-1:0] r_stream_id;
    logic                   r_load_state;
    logic                   r_new_stream_id;
    logic [BYTE_W-1:0]      r_char_in;
    logic                   r_char_in_vld;
    logic                   r_eop;
    logic                   r_result_valid;
    logic [STREAM_ID_W-1:0] r_result_stream_id;
    logic [NUM_REGEX-1:0]   r_result_fired;

    logic                   w_pkt_ready;
    logic                   w_accept;
    logic                   w_sop_seen;
    logic                   w_seen;
    logic [NUM_REGEX-1:0]   w_mask;
    logic [NUM_REGEX-1:0]   w_enable;

    // A sop arriving mid-stream is refused so it can open the next packet from IDLE.
    assign w_sop_seen  = pkt.pkt_valid && pkt.pkt_sop;
    assign w_pkt_ready = rst_n && ((r_state == ST_IDLE) ||
                                   ((r_state == ST_STREAM) && !w_sop_seen));
    assign w_accept    = pkt.pkt_valid && w_pkt_ready;
    assign w_enable    = r_eop ? w_mask : '0;

    dpi_stream_sequencer_table #(
        .NUM_REGEX (NUM_REGEX)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_we         (cfg_we),
        .i_wr_id      (cfg_stream_id),
        .i_wr_mask    (cfg_enable_mask),
        .i_rd_id      (r_stream_id),
        .o_rd_mask    (w_mask),
        .i_seen_id    (pkt.pkt_stream_id),
        .o_seen       (w_seen),
        .i_set_seen   (r_state == ST_EOP),
        .i_set_id     (r_stream_id),
        .i_clear_seen (cfg_clear_seen)
    );

    // Packet FSM with registered wrapper-side and result-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= ST_IDLE;
            r_cnt              <= '0;
            r_held             <= '0;
            r_held_eop         <= 1'b0;
            r_stream_id        <= '0;
            r_load_state       <= 1'b0;
            r_new_stream_id    <= 1'b0;
            r_char_in          <= '0;
            r_char_in_vld      <= 1'b0;
            r_eop              <= 1'b0;
            r_result_valid     <= 1'b0;
            r_result_stream_id <= '0;
            r_result_fired     <= '0;
        end else begin
            r_load_state <= 1'b0;
            r_eop        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && pkt.pkt_sop) begin
                        r_stream_id     <= pkt.pkt_stream_id;
                        r_held          <= pkt.pkt_data;
                        r_held_eop      <= pkt.pkt_eop;
                        r_new_stream_id <= ~w_seen;
                        r_load_state    <= 1'b1;
                        r_state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= cnt_preset(LOAD_GAP - 1);
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_char_in     <= r_held;
                        r_char_in_vld <= 1'b1;
                        if (r_held_eop) begin
                            r_cnt   <= cnt_preset(DRAIN);
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_STREAM: begin
                    r_char_in_vld <= w_accept;
                    if (w_accept) begin
                        r_char_in <= pkt.pkt_data;
                    end
                    if ((w_accept && pkt.pkt_eop) || w_sop_seen) begin
                        r_cnt   <= cnt_preset(DRAIN);
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_char_in_vld <= 1'b0;
                    if (r_cnt == '0) begin
                        r_eop   <= 1'b1;
                        r_state <= ST_EOP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_EOP: begin
                    r_result_fired     <= fired & w_enable;
                    r_result_stream_id <= r_stream_id;
                    r_result_valid     <= 1'b1;
                    r_state            <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DPI_SEQ_STATS_EN
    logic [31:0] r_stat_pkts;
    logic [31:0] r_stat_bytes;
    logic [15:0] r_stat_drops;

    // Free-running wrap-around counters: completed packets, issued chars, dropped beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_pkts  <= '0;
            r_stat_bytes <= '0;
            r_stat_drops <= '0;
        end else begin
            if (r_state == ST_EOP) begin
                r_stat_pkts <= r_stat_pkts + 32'd1;
            end
            if (r_char_in_vld) begin
                r_stat_bytes <= r_stat_bytes + 32'd1;
            end
            if ((r_state == ST_IDLE) && w_accept && !pkt.pkt_sop) begin
                r_stat_drops <= r_stat_drops + 16'd1;
            end
        end
    end

    assign stat_pkts  = r_stat_pkts;
    assign stat_bytes = r_stat_bytes;
    assign stat_drops = r_stat_drops;
`endif

    assign pkt.pkt_ready     = w_pkt_ready;
    assign stream_id         = r_stream_id;
    assign load_state        = r_load_state;
    assign new_stream_id     = r_new_stream_id;
    assign char_in           = r_char_in;
    assign char_in_vld       = r_char_in_vld;
    assign eop               = r_eop;
    assign enable            = w_enable;
    assign result_valid      = r_result_valid;
    assign result_stream_id  = r_result_stream_id;
    assign result_fired      = r_result_fired;
    assign busy              = (r_state != ST_IDLE);
endmodule
